solar_tracker_ctrl: RTL and testbench
=====================================

Name: solar_tracker_ctrl

Overview:
Parametrised four-axis sun-tracking motor controller. It compares opposing light-sensor pairs (north/south, east/west) against a threshold and drives exactly one of four motor enables. Over the single-threshold tracker it adds:
- configurable sensor width;
- overflow-safe comparison;
- dwell qualification against sensor chatter;
- hysteresis stop;
- a motor run-time watchdog with a sticky fault flag;
- a post-move cooldown.

It sits between the sensor ADC registers and the motor driver pins.

Parameters:
W, 8, sensor sample width in bits
TH, 10, start threshold: lead sensor must exceed opposite by strictly more than TH
HYST, 2, stop hysteresis; requires HYST < TH
DWELL, 4, consecutive qualifying sampling edges before motion starts; requires DWELL >= 1
MAX_RUN, 32, maximum motor-on cycles per move before watchdog trip; requires MAX_RUN >= 1
COOL, 8, idle cycles enforced after every move; requires COOL >= 1

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
lsn, lse, lss, lsw  in  W each  north/east/south/west light sensor samples
en  in  1  tracking enable
clr_to  in  1  single-cycle pulse, clears timeout flag
mn, me, ms, mw  out  1 each  motor enables, at most one high
busy  out  1  high when state != IDLE
timeout  out  1  sticky watchdog flag

Behaviour:
- Reset values: state IDLE, dir N, qcnt, rcnt and ccnt = 0, timeout = 0, all outputs 0.
- Reset mid-operation: outputs drop after the reset edge, and the timeout flag is cleared.
- Comparisons are done in W+1 bits, so a+TH never wraps.
- gt(a,b,k) means a > b+k, evaluated at width W+1.
- Candidate direction (priority N > E > S > W):
  - N if gt(lsn,lss,TH)
  - else E if gt(lse,lsw,TH)
  - else S if gt(lss,lsn,TH)
  - else W if gt(lsw,lse,TH)
  - else none.
- Stop condition for the latched dir: lead sensor <= opposite + HYST.
  - Example for N: not gt(lsn,lss,HYST).
- States: IDLE, QUAL, MOVE, COOL.
- IDLE:
  - If en and a candidate exists: latch dir, set qcnt = 1.
  - Then go to MOVE if DWELL == 1, otherwise go to QUAL.
  - Otherwise stay in IDLE.
- QUAL:
  - If not en, or candidate != dir: go to IDLE.
  - Else if qcnt+1 == DWELL: go to MOVE.
  - Else qcnt++.
  - Net effect: the motor asserts after the DWELL-th consecutive edge that samples the same candidate.
- MOVE:
  - On entry, rcnt = 0; rcnt increments each cycle spent in MOVE.
  - If not en, or the stop condition holds: go to COOL.
  - Else if rcnt == MAX_RUN-1: set timeout and go to COOL.
  - A normal stop and a watchdog trip on the same edge count as a normal stop; timeout is not set.
  - The motor is therefore high for at most MAX_RUN cycles.
- COOL:
  - ccnt counts COOL cycles, independent of en, then the block returns to IDLE.
  - Sensors are ignored during COOL.
- Outputs:
  - mX = (state == MOVE) && (dir == X), decoded from registers only; there is no combinational path from input to output.
- timeout flag:
  - Set by a watchdog trip, cleared by clr_to.
  - If set and clear happen on the same edge, set wins.
- Counter widths are $clog2 of (max count + 1).

Decomposition:
- Package solar_pkg holds:
  - the dir enum (N=0, E=1, S=2, W=3);
  - the state enum (IDLE, QUAL, MOVE, COOL).
- One sub-module, solar_cmp (parameter W):
  - inputs a, b, k; output a > b+k in W+1 bits;
  - instantiated 4 times for candidates and 4 times for stop checks.

Test Plan:
(Defaults throughout; all other sensors 50, en = 1.)
1. lsn=100, lss=89 held → mn rises after the 4th sampling edge. Then set lsn=91 → mn falls on the next edge; busy stays high 8 more cycles, then falls.
2. Boundary:
   - lsn=100, lss=90 (difference exactly TH) → no motor, busy stays 0.
   - Overflow check: lsn=255, lss=248 → no motor.
   - Wrap check: lss=250, lsn=5 → ms after 4 edges.
3. Chatter and priority:
   - N candidate for 3 edges, then lss=lsn → no motor output, busy returns to 0.
   - N and E qualify simultaneously → mn only.
4. Watchdog: lsn=200, lss=0 held → mn high for exactly 32 cycles, timeout=1, 8 cycles of cooldown, then mn again after 4 edges.
   - clr_to pulse → timeout=0.
   - clr_to coincident with a trip edge → timeout stays 1.
5. Enable drop: deassert en mid-MOVE → motor low on the next edge, then full COOL, then IDLE. en low in QUAL → IDLE.
6. rst asserted mid-MOVE with timeout=1 → all outputs, busy and timeout = 0 after the reset edge.

Source files
------------

// File: rtl/solar_pkg.sv
// Shared types for the sun-tracking motor controller: motor direction and FSM state.
package solar_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_MOVE = 2'd2,
        ST_COOL = 2'd3
    } state_t;

endpackage

// File: rtl/solar_tracker_ctrl_cmp.sv
// Overflow-safe threshold compare: gt = a > b + k, evaluated one bit wider than the samples.
module solar_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] k,
    output logic         gt
);

    logic [W:0] a_ext;
    logic [W:0] bk_sum;

    assign a_ext  = {1'b0, a};
    assign bk_sum = {1'b0, b} + {1'b0, k};
    assign gt     = (a_ext > bk_sum);

endmodule

// File: rtl/solar_tracker_ctrl.sv
// Four-axis sun-tracking motor controller with dwell qualification, hysteresis stop,
// run-time watchdog (sticky timeout flag) and post-move cooldown.
module solar_tracker_ctrl
    import solar_pkg::*;
#(
    parameter int W       = 8,
    parameter int TH      = 10,
    parameter int HYST    = 2,
    parameter int DWELL   = 4,
    parameter int MAX_RUN = 32,
    parameter int COOL    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] lsn,
    input  logic [W-1:0] lse,
    input  logic [W-1:0] lss,
    input  logic [W-1:0] lsw,
    input  logic         en,
    input  logic         clr_to,
    output logic         mn,
    output logic         me,
    output logic         ms,
    output logic         mw,
    output logic         busy,
    output logic         timeout
);

    localparam int QW = $clog2(DWELL + 1);
    localparam int RW = $clog2(MAX_RUN + 1);
    localparam int CW = $clog2(COOL + 1);

    localparam logic [W-1:0] TH_K   = W'(TH);
    localparam logic [W-1:0] HYST_K = W'(HYST);

    logic [W-1:0] sens [4];
    logic [3:0]   cand_gt;
    logic [3:0]   stop_gt;

    assign sens[0] = lsn;
    assign sens[1] = lse;
    assign sens[2] = lss;
    assign sens[3] = lsw;

    // Index i is the lead sensor for direction i; its opposite sits two positions away.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cmp
            solar_cmp #(.W(W)) u_cand (
                .a  (sens[gi]),
                .b  (sens[(gi + 2) % 4]),
                .k  (TH_K),
                .gt (cand_gt[gi])
            );
            solar_cmp #(.W(W)) u_stop (
                .a  (sens[gi]),
                .b  (sens[(gi + 2) % 4]),
                .k  (HYST_K),
                .gt (stop_gt[gi])
            );
        end
    endgenerate

    logic cand_valid;
    dir_t cand_dir;

    always_comb begin
        cand_valid = 1'b1;
        cand_dir   = DIR_N;
        if (cand_gt[0])      cand_dir = DIR_N;
        else if (cand_gt[1]) cand_dir = DIR_E;
        else if (cand_gt[2]) cand_dir = DIR_S;
        else if (cand_gt[3]) cand_dir = DIR_W;
        else                 cand_valid = 1'b0;
    end

    state_t          state_q, state_d;
    dir_t            dir_q, dir_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic [CW-1:0]   ccnt_q, ccnt_d;
    logic            timeout_q, timeout_d;
    logic [3:0]      mot_q, mot_d;
    logic            busy_q, busy_d;
    logic            trip;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        qcnt_d  = qcnt_q;
        rcnt_d  = rcnt_q;
        ccnt_d  = ccnt_q;
        trip    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && cand_valid) begin
                    dir_d  = cand_dir;
                    qcnt_d = QW'(1);
                    rcnt_d = '0;
                    state_d = (DWELL == 1) ? ST_MOVE : ST_QUAL;
                end
            end
            ST_QUAL: begin
                if (!en || !cand_valid || (cand_dir != dir_q)) begin
                    state_d = ST_IDLE;
                end else if (int'(qcnt_q) + 1 == DWELL) begin
                    state_d = ST_MOVE;
                    rcnt_d  = '0;
                end else begin
                    qcnt_d = qcnt_q + QW'(1);
                end
            end
            ST_MOVE: begin
                // A hysteresis stop takes precedence over a watchdog trip on the same edge.
                if (!en || !stop_gt[dir_q]) begin
                    state_d = ST_COOL;
                    ccnt_d  = '0;
                end else if (rcnt_q == RW'(MAX_RUN - 1)) begin
                    trip    = 1'b1;
                    state_d = ST_COOL;
                    ccnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            ST_COOL: begin
                if (ccnt_q == CW'(COOL - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ccnt_d = ccnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (trip)        timeout_d = 1'b1;
        else if (clr_to) timeout_d = 1'b0;
        else             timeout_d = timeout_q;

        mot_d  = (state_d == ST_MOVE) ? (4'b0001 << dir_d) : 4'b0000;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_N;
            qcnt_q    <= '0;
            rcnt_q    <= '0;
            ccnt_q    <= '0;
            timeout_q <= 1'b0;
            mot_q     <= 4'b0000;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            qcnt_q    <= qcnt_d;
            rcnt_q    <= rcnt_d;
            ccnt_q    <= ccnt_d;
            timeout_q <= timeout_d;
            mot_q     <= mot_d;
            busy_q    <= busy_d;
        end
    end

    assign mn      = mot_q[0];
    assign me      = mot_q[1];
    assign ms      = mot_q[2];
    assign mw      = mot_q[3];
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_solar_tracker_ctrl.sv
// Directed bench for solar_tracker_ctrl with default parameters; motor vector shown as {mn,me,ms,mw}.
module tb_solar_tracker_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] lsn, lse, lss, lsw;
    logic       en;
    logic       clr_to;
    logic       mn, me, ms, mw;
    logic       busy;
    logic       timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    solar_tracker_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .lsn     (lsn),
        .lse     (lse),
        .lss     (lss),
        .lsw     (lsw),
        .en      (en),
        .clr_to  (clr_to),
        .mn      (mn),
        .me      (me),
        .ms      (ms),
        .mw      (mw),
        .busy    (busy),
        .timeout (timeout)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sensors(input logic [7:0] n, e, s, w);
        lsn = n; lse = e; lss = s; lsw = w;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %s: observed=%0h expected=%0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] motors();
        return {28'd0, mn, me, ms, mw};
    endfunction

    initial begin
        rst = 1'b1; en = 1'b1; clr_to = 1'b0;
        sensors(8'd50, 8'd50, 8'd50, 8'd50);
        step(2);
        rst = 1'b0;
        check("reset_motors", motors(), 32'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_timeout", timeout, 1'b0);

        // Basic north move, hysteresis stop, cooldown
        sensors(8'd100, 8'd50, 8'd89, 8'd50);
        step(3);
        check("n_qual_no_motor", motors(), 32'h0);
        check("n_qual_busy", busy, 1'b1);
        step(1);
        check("n_move_mn", motors(), 32'h8);
        lsn = 8'd91;
        step(1);
        check("n_stop_motor", motors(), 32'h0);
        check("n_cool_busy", busy, 1'b1);
        sensors(8'd50, 8'd50, 8'd50, 8'd50);
        step(7);
        check("n_cool_busy_end", busy, 1'b1);
        step(1);
        check("n_idle_busy", busy, 1'b0);

        // Difference exactly TH, and near-full-scale without wrap
        sensors(8'd100, 8'd50, 8'd90, 8'd50);
        step(6);
        check("eq_th_motor", motors(), 32'h0);
        check("eq_th_busy", busy, 1'b0);
        sensors(8'd255, 8'd50, 8'd248, 8'd50);
        step(6);
        check("ovf_motor", motors(), 32'h0);
        check("ovf_busy", busy, 1'b0);
        sensors(8'd5, 8'd50, 8'd250, 8'd50);
        step(3);
        check("wrap_qual", motors(), 32'h0);
        step(1);
        check("wrap_ms", motors(), 32'h2);
        sensors(8'd50, 8'd50, 8'd50, 8'd50);
        step(1);
        check("wrap_stop", motors(), 32'h0);
        step(8);
        check("wrap_idle", busy, 1'b0);

        // Chatter during qualification
        sensors(8'd100, 8'd50, 8'd89, 8'd50);
        step(3);
        check("chat_busy", busy, 1'b1);
        lss = 8'd100;
        step(1);
        check("chat_abort_busy", busy, 1'b0);
        sensors(8'd50, 8'd50, 8'd50, 8'd50);
        step(4);
        check("chat_motor", motors(), 32'h0);

        // N and E both qualify: N wins
        sensors(8'd100, 8'd100, 8'd50, 8'd50);
        step(4);
        check("prio_mn", motors(), 32'h8);
        sensors(8'd50, 8'd50, 8'd50, 8'd50);
        step(1);
        check("prio_stop", motors(), 32'h0);
        step(8);
        check("prio_idle", busy, 1'b0);

        // Watchdog
        sensors(8'd200, 8'd50, 8'd0, 8'd50);
        step(4);
        check("wd_mn_on", motors(), 32'h8);
        step(31);
        check("wd_mn_32", motors(), 32'h8);
        check("wd_to_pre", timeout, 1'b0);
        step(1);
        check("wd_mn_off", motors(), 32'h0);
        check("wd_to_set", timeout, 1'b1);
        step(7);
        check("wd_cool_busy", busy, 1'b1);
        step(1);
        check("wd_idle", busy, 1'b0);
        step(3);
        check("wd_requal", motors(), 32'h0);
        step(1);
        check("wd_remove", motors(), 32'h8);
        clr_to = 1'b1;
        step(1);
        clr_to = 1'b0;
        check("clr_to", timeout, 1'b0);
        step(30);
        clr_to = 1'b1;
        step(1);
        clr_to = 1'b0;
        check("clr_vs_trip_to", timeout, 1'b1);
        check("clr_vs_trip_mot", motors(), 32'h0);

        // Reset in MOVE with timeout set
        step(12);
        check("rst_pre_mn", motors(), 32'h8);
        check("rst_pre_to", timeout, 1'b1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_mot", motors(), 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_to", timeout, 1'b0);

        // Enable drop in MOVE and in QUAL
        step(4);
        check("en_move", motors(), 32'h8);
        en = 1'b0;
        step(1);
        en = 1'b1;
        check("en_drop_mot", motors(), 32'h0);
        check("en_drop_busy", busy, 1'b1);
        step(7);
        check("en_cool_busy", busy, 1'b1);
        step(1);
        check("en_idle", busy, 1'b0);
        step(2);
        check("en_qual_busy", busy, 1'b1);
        en = 1'b0;
        step(1);
        check("en_qual_abort", busy, 1'b0);
        step(4);
        check("en_low_mot", motors(), 32'h0);
        check("en_low_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
